stage_write_back_lc: RTL and testbench

Parametrised write-back stage with a registered pipeline slot, little-endian load-data alignment and sign extension, and arbitration of the single register-file write port between the in-order pipeline and a long-latency completion channel (divider/multiplier results). It sits after the memory stage and drives the register-file write port, replacing the single-source write-back stage. Queued completions are killed when a younger pipeline write targets the same register; a starvation counter requests one upstream bubble when a completion waits too long.

---
 rtl/stage_write_back_lc_pkg.sv | 22 ++
 rtl/stage_write_back_lc_load_aligner.sv | 64 ++++++
 rtl/stage_write_back_lc.sv | 220 ++++++++++++++++++++++
 tb/tb_stage_write_back_lc.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_write_back_lc_pkg.sv
// ---------------------------------------------------------------------------
// selector: shared selector encodings for the pipeline back end.
//   reg_src_t   : which result feeds the register-file write (ALU or memory).
//   load_type_t : access size of a load, used by the load aligner.
// ---------------------------------------------------------------------------
package selector;

    typedef enum logic {
        REG_SRC_ALU = 1'b0,
        REG_SRC_MEM = 1'b1
    } reg_src_t;

    // DOUBLE is only meaningful on a 64-bit datapath; a 32-bit datapath
    // treats it as a full-width word.
    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } load_type_t;

endpackage

// File: rtl/stage_write_back_lc_load_aligner.sv
// ---------------------------------------------------------------------------
// load_aligner: little-endian lane selection plus zero/sign extension of a
// raw memory word.
//   load_type   : access size (BYTE/HALF/WORD/DOUBLE)
//   load_signed : sign-extend the selected lane
//   offset      : byte offset inside the word; low bits below the access
//                 size are ignored (misalignment is trapped upstream)
//   raw         : raw memory word
//   value       : aligned, extended result
// Purely combinational.
// ---------------------------------------------------------------------------
module load_aligner
    import selector::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  load_type_t        load_type,
    input  logic              load_signed,
    input  logic [OFF_W-1:0]  offset,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] value
);

    localparam logic [DATA_W-1:0] MASK_B = DATA_W'(8'hFF);
    localparam logic [DATA_W-1:0] MASK_H = DATA_W'(16'hFFFF);
    localparam logic [DATA_W-1:0] MASK_W = DATA_W'(32'hFFFF_FFFF);

    logic [OFF_W-1:0]  off_m;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] shifted;
    logic              sign_bit;

    always_comb begin
        off_m    = offset;
        mask     = '1;
        sign_bit = 1'b0;
        case (load_type)
            BYTE: mask = MASK_B;
            HALF: begin
                off_m[0] = 1'b0;
                mask     = MASK_H;
            end
            WORD: begin
                off_m[1:0] = 2'b00;
                mask       = MASK_W;
            end
            default: off_m = '0;
        endcase

        shifted = raw >> {off_m, 3'b000};

        case (load_type)
            BYTE:    sign_bit = shifted[7];
            HALF:    sign_bit = shifted[15];
            WORD:    sign_bit = shifted[31];
            default: sign_bit = 1'b0;
        endcase

        // Bits above the lane come from the sign bit or are zero.
        value = (shifted & mask) | ({DATA_W{load_signed & sign_bit}} & ~mask);
    end

endmodule

// File: rtl/stage_write_back_lc.sv
// ---------------------------------------------------------------------------
// stage_write_back_lc: write-back stage sharing the single register-file
// write port between the in-order pipeline slot and a queue of long-latency
// completions (divider / multiplier results).
//
// Ports
//   clk, reset (async, active high)
//   stall, nullify           : slot hold / slot clear
//   in_*                     : memory-stage result captured into the slot
//   lc_valid/lc_ready,
//   lc_dest, lc_data         : completion channel into the queue
//   rf_we, rf_waddr, rf_wdata: register-file write port
//   wb_bubble_req            : one-cycle request for an upstream bubble
//   lc_pending               : per-register "completion still queued" flags
//
// Handshake: a completion is transferred on a rising clk edge where
// lc_valid && lc_ready. lc_ready depends only on the registered queue
// count, so a pop in the same cycle never frees room for a push when full.
//
// A slot write always owns the port; the queue head writes only in cycles
// without one. A slot write to register r kills every queued entry for r
// (the pipeline value is younger), including one arriving in that cycle.
// Killed entries and entries for r0 keep their FIFO position and are
// popped without a write.
// ---------------------------------------------------------------------------
module stage_write_back_lc
    import selector::*;
#(
    parameter int DATA_W       = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int LC_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     nullify,
    input  logic                     in_valid,
    input  logic                     in_we,
    input  selector::reg_src_t       in_reg_src,
    input  selector::load_type_t     in_load_type,
    input  logic                     in_load_signed,
    input  logic [$clog2(DATA_W/8)-1:0] in_addr_low,
    input  logic [REG_ADDR_W-1:0]    in_dest,
    input  logic [DATA_W-1:0]        in_alu_data,
    input  logic [DATA_W-1:0]        in_mem_data,
    input  logic                     lc_valid,
    output logic                     lc_ready,
    input  logic [REG_ADDR_W-1:0]    lc_dest,
    input  logic [DATA_W-1:0]        lc_data,
    output logic                     rf_we,
    output logic [REG_ADDR_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic                     wb_bubble_req,
    output logic [2**REG_ADDR_W-1:0] lc_pending
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int PTR_W = $clog2(LC_DEPTH);
    localparam int CNT_W = $clog2(LC_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LC_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(LC_DEPTH);
    localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_LIMIT);

    // ---------------- pipeline slot ----------------
    logic                  slot_valid;
    logic                  slot_we;
    reg_src_t              slot_src;
    load_type_t            slot_type;
    logic                  slot_signed;
    logic [OFF_W-1:0]      slot_off;
    logic [REG_ADDR_W-1:0] slot_dest;
    logic [DATA_W-1:0]     slot_alu;
    logic [DATA_W-1:0]     slot_mem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid  <= 1'b0;
            slot_we     <= 1'b0;
            slot_src    <= REG_SRC_ALU;
            slot_type   <= BYTE;
            slot_signed <= 1'b0;
            slot_off    <= '0;
            slot_dest   <= '0;
            slot_alu    <= '0;
            slot_mem    <= '0;
        end else if (nullify) begin
            slot_valid <= 1'b0;
        end else if (!stall) begin
            slot_valid  <= in_valid;
            slot_we     <= in_we;
            slot_src    <= in_reg_src;
            slot_type   <= in_load_type;
            slot_signed <= in_load_signed;
            slot_off    <= in_addr_low;
            slot_dest   <= in_dest;
            slot_alu    <= in_alu_data;
            slot_mem    <= in_mem_data;
        end
    end

    logic [DATA_W-1:0] load_value;

    load_aligner #(.DATA_W(DATA_W)) u_load_aligner (
        .load_type   (slot_type),
        .load_signed (slot_signed),
        .offset      (slot_off),
        .raw         (slot_mem),
        .value       (load_value)
    );

    logic              slot_wr;
    logic [DATA_W-1:0] slot_data;

    assign slot_wr   = slot_valid && slot_we && (slot_dest != '0);
    assign slot_data = (slot_src == REG_SRC_MEM) ? load_value : slot_alu;

    // ---------------- completion queue ----------------
    logic [REG_ADDR_W-1:0] q_dest  [LC_DEPTH];
    logic [DATA_W-1:0]     q_data  [LC_DEPTH];
    logic                  q_valid [LC_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [STV_W-1:0]      starve_cnt;

    logic head_live;
    logic blocked;
    logic pop;
    logic push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign lc_ready  = (count < DEPTH_C);
    assign push      = lc_valid && lc_ready;
    assign head_live = (count != '0) && q_valid[rd_ptr];
    assign blocked   = head_live && slot_wr;
    // Dead heads leave regardless of the slot; live heads only when the
    // port is free.
    assign pop       = (count != '0) && !blocked;

    assign wb_bubble_req = (starve_cnt == STARVE_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LC_DEPTH; i++) begin
                q_dest[i]  <= '0;
                q_data[i]  <= '0;
                q_valid[i] <= 1'b0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            for (int i = 0; i < LC_DEPTH; i++) begin
                if (slot_wr && (q_dest[i] == slot_dest)) begin
                    q_valid[i] <= 1'b0;
                end
            end

            // Clearing on pop keeps unoccupied entries invalid, which
            // lc_pending relies on.
            if (pop) begin
                q_valid[rd_ptr] <= 1'b0;
                rd_ptr          <= ptr_inc(rd_ptr);
            end

            if (push) begin
                q_dest[wr_ptr]  <= lc_dest;
                q_data[wr_ptr]  <= lc_data;
                q_valid[wr_ptr] <= (lc_dest != '0) &&
                                   !(slot_wr && (lc_dest == slot_dest));
                wr_ptr          <= ptr_inc(wr_ptr);
            end

            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            if ((count == '0) || pop || wb_bubble_req) begin
                starve_cnt <= '0;
            end else if (blocked) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        lc_pending = '0;
        for (int i = 0; i < LC_DEPTH; i++) begin
            if (q_valid[i]) begin
                lc_pending[q_dest[i]] = 1'b1;
            end
        end
    end

    // ---------------- write port ----------------
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (slot_wr) begin
            rf_we    = 1'b1;
            rf_waddr = slot_dest;
            rf_wdata = slot_data;
        end else if (head_live) begin
            rf_we    = 1'b1;
            rf_waddr = q_dest[rd_ptr];
            rf_wdata = q_data[rd_ptr];
        end
    end

endmodule

// File: tb/tb_stage_write_back_lc.sv
module tb_stage_write_back_lc;
  import selector::*;

  localparam int DATA_W       = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int LC_DEPTH     = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int NREG         = 1 << REG_ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                  stall, nullify, in_valid, in_we, in_load_signed;
  reg_src_t              in_reg_src;
  load_type_t            in_load_type;
  logic [1:0]            in_addr_low;
  logic [REG_ADDR_W-1:0] in_dest, lc_dest, rf_waddr;
  logic [DATA_W-1:0]     in_alu_data, in_mem_data, lc_data, rf_wdata;
  logic                  lc_valid, lc_ready, rf_we, wb_bubble_req;
  logic [NREG-1:0]       lc_pending;

  stage_write_back_lc #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W),
    .LC_DEPTH(LC_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .nullify(nullify),
    .in_valid(in_valid), .in_we(in_we), .in_reg_src(in_reg_src),
    .in_load_type(in_load_type), .in_load_signed(in_load_signed),
    .in_addr_low(in_addr_low), .in_dest(in_dest),
    .in_alu_data(in_alu_data), .in_mem_data(in_mem_data),
    .lc_valid(lc_valid), .lc_ready(lc_ready), .lc_dest(lc_dest),
    .lc_data(lc_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .wb_bubble_req(wb_bubble_req),
    .lc_pending(lc_pending)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
    bit                    live;
  } lc_entry_t;

  lc_entry_t             mq[$];
  bit                    ms_valid, ms_we, ms_sgn;
  reg_src_t              ms_src;
  load_type_t            ms_type;
  int                    ms_off;
  logic [REG_ADDR_W-1:0] ms_dest;
  logic [DATA_W-1:0]     ms_alu, ms_mem;
  int                    m_wait;

  // scoreboard for the in-order drain test
  logic [DATA_W-1:0] exp_q[$];
  bit                sb_on;
  int                sb_seen;

  int checks;
  int errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_align(load_type_t t, bit sgn, int off,
                                                  logic [DATA_W-1:0] raw);
    int nbytes;
    longint unsigned val, mask;
    case (t)
      BYTE:    nbytes = 1;
      HALF:    nbytes = 2;
      default: nbytes = 4;
    endcase
    off  = off - (off % nbytes);
    val  = longint'(raw) >> (8 * off);
    mask = (64'd1 << (8 * nbytes)) - 64'd1;
    val  = val & mask;
    if (sgn && (((val >> (8 * nbytes - 1)) & 64'd1) == 64'd1)) val = val | ~mask;
    return val[DATA_W-1:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    ms_valid = 0; ms_we = 0; ms_sgn = 0; ms_src = REG_SRC_ALU; ms_type = BYTE;
    ms_off = 0; ms_dest = '0; ms_alu = '0; ms_mem = '0; m_wait = 0;
  endtask

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_step();
    bit slot_wr, blocked, drain;
    int old_size;
    if (reset) begin
      model_reset();
      return;
    end
    slot_wr  = ms_valid && ms_we && (ms_dest != 0);
    old_size = mq.size();
    blocked  = (old_size > 0) && mq[0].live && slot_wr;
    drain    = (old_size > 0) && !blocked;
    if (sb_on && lc_valid && old_size < LC_DEPTH) exp_q.push_back(lc_data);
    if (old_size == 0 || drain || m_wait == STARVE_LIMIT) m_wait = 0;
    else m_wait = m_wait + 1;
    foreach (mq[i]) if (slot_wr && mq[i].dest == ms_dest) mq[i].live = 0;
    if (drain) void'(mq.pop_front());
    if (lc_valid && old_size < LC_DEPTH) begin
      lc_entry_t e;
      e.dest = lc_dest;
      e.data = lc_data;
      e.live = (lc_dest != 0) && !(slot_wr && lc_dest == ms_dest);
      mq.push_back(e);
    end
    if (nullify) ms_valid = 0;
    else if (!stall) begin
      ms_valid = in_valid; ms_we = in_we; ms_src = in_reg_src;
      ms_type = in_load_type; ms_sgn = in_load_signed; ms_off = int'(in_addr_low);
      ms_dest = in_dest; ms_alu = in_alu_data; ms_mem = in_mem_data;
    end
  endtask

  task automatic compare_outputs();
    bit                    slot_wr, e_we;
    logic [REG_ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0]     e_data;
    logic [NREG-1:0]       e_pend;
    slot_wr = ms_valid && ms_we && (ms_dest != 0);
    e_we = 0; e_addr = '0; e_data = '0; e_pend = '0;
    if (slot_wr) begin
      e_we = 1; e_addr = ms_dest;
      e_data = (ms_src == REG_SRC_MEM) ? ref_align(ms_type, ms_sgn, ms_off, ms_mem) : ms_alu;
    end else if (mq.size() > 0 && mq[0].live) begin
      e_we = 1; e_addr = mq[0].dest; e_data = mq[0].data;
    end
    foreach (mq[i]) if (mq[i].live) e_pend[mq[i].dest] = 1'b1;
    check("rf_we", 64'(rf_we), 64'(e_we));
    check("rf_waddr", 64'(rf_waddr), 64'(e_addr));
    check("rf_wdata", 64'(rf_wdata), 64'(e_data));
    check("lc_ready", 64'(lc_ready), 64'(mq.size() < LC_DEPTH));
    check("lc_pending", 64'(lc_pending), 64'(e_pend));
    check("wb_bubble_req", 64'(wb_bubble_req), 64'(m_wait == STARVE_LIMIT));
    if (sb_on && rf_we && rf_waddr >= 10 && rf_waddr <= 19) begin
      sb_seen++;
      if (exp_q.size() == 0) check("drain_extra", 64'(rf_wdata), 64'hDEAD);
      else check("drain_order", 64'(rf_wdata), 64'(exp_q.pop_front()));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic drive_idle();
    stall = 0; nullify = 0; in_valid = 0; in_we = 0; in_reg_src = REG_SRC_ALU;
    in_load_type = BYTE; in_load_signed = 0; in_addr_low = '0; in_dest = '0;
    in_alu_data = '0; in_mem_data = '0; lc_valid = 0; lc_dest = '0; lc_data = '0;
  endtask

  task automatic drive_slot(input logic [REG_ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
    in_valid = 1; in_we = 1; in_reg_src = REG_SRC_ALU; in_dest = d; in_alu_data = v;
  endtask

  task automatic drive_lc(input logic [REG_ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
    lc_valid = 1; lc_dest = d; lc_data = v;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1;
    tick();
    reset = 0;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rf_we"}, 64'(rf_we), 64'd0);
    check({tag, "_rf_waddr"}, 64'(rf_waddr), 64'd0);
    check({tag, "_rf_wdata"}, 64'(rf_wdata), 64'd0);
    check({tag, "_bubble"}, 64'(wb_bubble_req), 64'd0);
    check({tag, "_pending"}, 64'(lc_pending), 64'd0);
    check({tag, "_lc_ready"}, 64'(lc_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int waited, sent, density;
    bit acc;
    checks = 0; errors = 0; sb_on = 0; sb_seen = 0;
    model_reset();
    drive_idle();
    reset = 1;
    tick();
    check_reset_values("reset");
    reset = 0;
    tick();

    // Alignment through the slot
    in_valid = 1; in_we = 1; in_dest = 6; in_reg_src = REG_SRC_MEM;
    in_load_type = BYTE; in_load_signed = 1; in_addr_low = 2'd3; in_mem_data = 32'h8011_2233;
    tick();
    check("lb_signed_data", 64'(rf_wdata), 64'hFFFF_FF80);
    check("lb_signed_addr", 64'(rf_waddr), 64'd6);
    in_load_type = HALF; in_load_signed = 0; in_addr_low = 2'd2;
    tick();
    check("lhu_data", 64'(rf_wdata), 64'h0000_8011);
    drive_idle();
    tick();

    // Priority: slot write beats a same-cycle completion
    do_reset();
    drive_slot(7, 32'h77);
    drive_lc(4, 32'hAA);
    tick();
    check("prio_slot_addr", 64'(rf_waddr), 64'd7);
    check("prio_slot_we", 64'(rf_we), 64'd1);
    drive_idle();
    tick();
    check("prio_lc_addr", 64'(rf_waddr), 64'd4);
    check("prio_lc_data", 64'(rf_wdata), 64'hAA);

    // Kill: younger slot write to r9 cancels the queued r9
    do_reset();
    drive_slot(3, 32'h33);
    drive_lc(9, 32'h99);
    tick();
    check("kill_pending_set", 64'(lc_pending[9]), 64'd1);
    drive_idle();
    drive_slot(9, 32'h9);
    tick();
    check("kill_slot_addr", 64'(rf_waddr), 64'd9);
    drive_idle();
    tick();
    check("kill_pending_clr", 64'(lc_pending[9]), 64'd0);
    check("kill_no_write", 64'(rf_we), 64'd0);
    tick();
    check("kill_empty_ready", 64'(lc_ready), 64'd1);

    // Full and wrap: 4 pushes under continuous slot writes, then drain
    do_reset();
    sb_on = 1; sb_seen = 0; exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      drive_slot(1, 32'(i));
      drive_lc(5'(10 + i), 32'h100 + 32'(i));
      tick();
    end
    check("full_not_ready", 64'(lc_ready), 64'd0);
    drive_lc(14, 32'h104);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_holds", 64'(lc_ready), 64'd0);
    end
    in_valid = 0;
    sent = 0;
    for (int i = 0; i < 40 && (sent < 6 || mq.size() > 0); i++) begin
      acc = lc_valid && (mq.size() < LC_DEPTH);
      tick();
      if (acc) sent++;
      if (sent < 6) drive_lc(5'(14 + sent), 32'h104 + 32'(sent));
      else lc_valid = 0;
    end
    check("wrap_all_sent", 64'(sent), 64'd6);
    check("wrap_all_drained", 64'(sb_seen), 64'd10);
    check("wrap_sb_empty", 64'(exp_q.size()), 64'd0);
    sb_on = 0;
    drive_idle();

    // Starvation: bubble request after STARVE_LIMIT blocked cycles
    do_reset();
    drive_slot(2, 32'h22);
    drive_lc(5, 32'h55);
    tick();
    lc_valid = 0;
    waited = 0;
    while (!wb_bubble_req && waited < 20) begin
      tick();
      waited++;
    end
    check("starve_wait", 64'(waited), 64'd8);
    in_valid = 0;
    tick();
    check("starve_drain_we", 64'(rf_we), 64'd1);
    check("starve_drain_addr", 64'(rf_waddr), 64'd5);
    check("starve_drain_data", 64'(rf_wdata), 64'h55);
    check("starve_pulse_end", 64'(wb_bubble_req), 64'd0);

    // Reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_slot(1, 32'h1);
      drive_lc(5'(20 + i), 32'h200 + 32'(i));
      tick();
    end
    drive_idle();
    tick();
    tick();
    check("middrain_writing", 64'(rf_we), 64'd1);
    reset = 1;
    #1;
    check_reset_values("async_reset");
    tick();
    reset = 0;
    tick();
    check("after_reset_no_write", 64'(rf_we), 64'd0);
    tick();
    check("after_reset_no_write2", 64'(rf_we), 64'd0);

    // Randomized traffic against the model
    density = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) density = $urandom_range(20, 95);
      reset          = ($urandom_range(0, 299) == 0);
      stall          = ($urandom_range(0, 9) == 0);
      nullify        = ($urandom_range(0, 14) == 0);
      in_valid       = ($urandom_range(0, 99) < density);
      in_we          = ($urandom_range(0, 5) != 0);
      in_reg_src     = reg_src_t'($urandom_range(0, 1));
      in_load_type   = load_type_t'($urandom_range(0, 3));
      in_load_signed = $urandom_range(0, 1);
      in_addr_low    = 2'($urandom_range(0, 3));
      in_dest        = 5'($urandom_range(0, 7));
      in_alu_data    = $urandom;
      in_mem_data    = $urandom;
      lc_valid       = ($urandom_range(0, 2) == 0);
      lc_dest        = 5'($urandom_range(0, 7));
      lc_data        = $urandom;
      tick();
    end
    reset = 0;
    drive_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
